// File: rtl/st2_branch_resolver_pkg.sv
// Shared definitions for the serial branch resolver: condition codes,
// relation encodings, FSM states and the taken-decode helper.
// Ports: none (package).
package st2_branch_resolver_pkg;

    typedef enum logic [2:0] {
        COND_BEQ    = 3'b000,
        COND_BNE    = 3'b001,
        COND_BLT    = 3'b010,
        COND_BGE    = 3'b011,
        COND_BGT    = 3'b100,
        COND_BLE    = 3'b101,
        COND_ALWAYS = 3'b110,
        COND_NEVER  = 3'b111
    } cond_e;

    localparam logic [1:0] RES_EQ = 2'b00;
    localparam logic [1:0] RES_GT = 2'b01;
    localparam logic [1:0] RES_LT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CMP  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Branch decision from the final relation of op1 to op2.
    function automatic logic decode_taken(input cond_e c, input logic [1:0] r);
        logic eq;
        logic gt;
        logic lt;
        eq = (r == RES_EQ);
        gt = (r == RES_GT);
        lt = (r == RES_LT);
        case (c)
            COND_BEQ:    decode_taken = eq;
            COND_BNE:    decode_taken = !eq;
            COND_BLT:    decode_taken = lt;
            COND_BGE:    decode_taken = !lt;
            COND_BGT:    decode_taken = gt;
            COND_BLE:    decode_taken = !gt;
            COND_ALWAYS: decode_taken = 1'b1;
            default:     decode_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/st2_branch_resolver_chunk_cmp.sv
// Combinational compare of one CHUNK-bit slice; latency 0, no backpressure.
// Ports: a_i/b_i slices, inv_msb_i flips both slice MSBs (signed top slice),
//        eq_o slices equal, gt_o a greater than b (unsigned after flip).
module st2_chunk_cmp #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             inv_msb_i,
    output logic             eq_o,
    output logic             gt_o
);

    logic [CHUNK-1:0] mask;
    logic [CHUNK-1:0] a_x;
    logic [CHUNK-1:0] b_x;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_comb begin
        mask            = '0;
        mask[CHUNK-1]   = inv_msb_i;
        a_x             = a_i ^ mask;
        b_x             = b_i ^ mask;
        eq_o            = (a_x == b_x);
        gt_o            = (a_x > b_x);
    end

endmodule

// File: rtl/st2_branch_resolver.sv
// Serial branch resolver: compares op1/op2 one CHUNK slice per cycle, MSB first.
// Latency: 1..NCHUNK cycles from accept to out_valid (early exit on first unequal slice).
// Backpressure: result held in DONE until out_ready; one request in flight; flush squashes.
// Ports: clk/rst_n; in_valid/in_ready/op1/op2/cond/signed_mode request side;
//        flush abort; out_valid/out_ready/result/taken result side; taken_cnt statistics.
module st2_branch_resolver
    import st2_branch_resolver_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [2:0]       cond,
    input  logic             signed_mode,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       result,
    output logic             taken,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   op1_q, op1_d;
    logic [WIDTH-1:0]   op2_q, op2_d;
    cond_e              cond_q, cond_d;
    logic               sgn_q, sgn_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         result_q, result_d;
    logic               taken_q, taken_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [CHUNK-1:0]   a_slice;
    logic [CHUNK-1:0]   b_slice;
    logic               slice_inv;
    logic               slice_eq;
    logic               slice_gt;
    logic [1:0]         slice_res;

    always_comb begin
        a_slice   = op1_q[int'(idx_q)*CHUNK +: CHUNK];
        b_slice   = op2_q[int'(idx_q)*CHUNK +: CHUNK];
        // Only the top slice carries the sign bit.
        slice_inv = sgn_q && (idx_q == IDX_TOP);
    end

    st2_chunk_cmp #(
        .CHUNK (CHUNK)
    ) u_chunk_cmp (
        .a_i       (a_slice),
        .b_i       (b_slice),
        .inv_msb_i (slice_inv),
        .eq_o      (slice_eq),
        .gt_o      (slice_gt)
    );

    always_comb begin
        if (slice_eq)      slice_res = RES_EQ;
        else if (slice_gt) slice_res = RES_GT;
        else               slice_res = RES_LT;
    end

    always_comb begin
        state_d  = state_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        cond_d   = cond_q;
        sgn_d    = sgn_q;
        idx_d    = idx_q;
        result_d = result_q;
        taken_d  = taken_q;
        cnt_d    = cnt_q;

        if (flush) begin
            // Squash wins over accept and transfer; nothing else changes.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op1_d   = op1;
                        op2_d   = op2;
                        cond_d  = cond_e'(cond);
                        sgn_d   = signed_mode;
                        idx_d   = IDX_TOP;
                        state_d = ST_CMP;
                    end
                end
                ST_CMP: begin
                    // Finish on the first unequal slice or after the last one.
                    if (!slice_eq || idx_q == '0) begin
                        result_d = slice_res;
                        taken_d  = decode_taken(cond_q, slice_res);
                        state_d  = ST_DONE;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                        if (taken_q && (cnt_q != '1)) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op1_q    <= '0;
            op2_q    <= '0;
            cond_q   <= COND_BEQ;
            sgn_q    <= 1'b0;
            idx_q    <= '0;
            result_q <= RES_EQ;
            taken_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            cond_q   <= cond_d;
            sgn_q    <= sgn_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            taken_q  <= taken_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign taken     = taken_q;
    assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_st2_branch_resolver.sv
// Directed bench for st2_branch_resolver (WIDTH=16, CHUNK=4, CNT_W=8).
// Inputs are driven 1 time unit after each rising edge and sampled there too.
module tb_st2_branch_resolver;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [2:0]  cond;
    logic        signed_mode;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  result;
    logic        taken;
    logic [7:0]  taken_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    st2_branch_resolver #(
        .WIDTH (16),
        .CHUNK (4),
        .CNT_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op1         (op1),
        .op2         (op2),
        .cond        (cond),
        .signed_mode (signed_mode),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .taken       (taken),
        .taken_cnt   (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request and return the number of cycles until out_valid (99 on timeout).
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [2:0] c,
                         input logic s, output int lat);
        check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        op1 = a; op2 = b; cond = c; signed_mode = s; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        if (!out_valid) lat = 99;
    endtask

    // Full transaction: latency, result, taken, then transfer and counter.
    task automatic txn(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] c, input logic s, input int exp_lat,
                       input logic [1:0] exp_res, input logic exp_tk, input logic [7:0] exp_cnt);
        int lat;
        issue(a, b, c, s, lat);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, {30'b0, result}, {30'b0, exp_res});
        check({tag, "_taken"}, {31'b0, taken}, {31'b0, exp_tk});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_idle_after"}, {30'b0, in_ready, out_valid}, 32'h2);
        check({tag, "_cnt"}, {24'b0, taken_cnt}, {24'b0, exp_cnt});
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; op1 = '0; op2 = '0; cond = '0;
        signed_mode = 1'b0; flush = 1'b0; out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_result", {30'b0, result}, 32'd0);
        check("reset_taken", {31'b0, taken}, 32'd0);
        check("reset_cnt", {24'b0, taken_cnt}, 32'd0);

        // name            op1       op2       cond    sgn  lat res    tk cnt
        txn("beq_zero",   16'h0000, 16'h0000, 3'b000, 0,   4, 2'b00, 1, 8'd1);
        txn("bgt_lsb",    16'h0001, 16'h0000, 3'b100, 0,   4, 2'b01, 1, 8'd2);
        txn("ble_lsb",    16'h0001, 16'h0000, 3'b101, 0,   4, 2'b01, 0, 8'd2);
        txn("blt_signed", 16'h8000, 16'h0001, 3'b010, 1,   1, 2'b10, 1, 8'd3);
        txn("blt_unsgn",  16'h8000, 16'h0001, 3'b010, 0,   1, 2'b01, 0, 8'd3);
        txn("bne_mid",    16'h1234, 16'h1244, 3'b001, 0,   3, 2'b10, 1, 8'd4);
        txn("bge_eq",     16'hABCD, 16'hABCD, 3'b011, 1,   4, 2'b00, 1, 8'd5);
        txn("never_eq",   16'h0000, 16'h0000, 3'b111, 0,   4, 2'b00, 0, 8'd5);

        // Held result under backpressure.
        issue(16'hFFFA, 16'hFFFF, 3'b010, 1'b1, lat);
        check("hold_latency", lat, 32'd4);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_result", {30'b0, result}, 32'h2);
            check("hold_taken", {31'b0, taken}, 32'd1);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
            step();
        end
        // A fresh request offered during the transfer must not be taken.
        out_ready = 1'b1; in_valid = 1'b1;
        step();
        out_ready = 1'b0; in_valid = 1'b0;
        check("hold_cnt", {24'b0, taken_cnt}, 32'd6);
        check("hold_single_xfer", {30'b0, in_ready, out_valid}, 32'h2);
        step();
        check("no_accept_on_xfer", {31'b0, in_ready}, 32'd1);

        // Flush in the second compare cycle.
        op1 = 16'h0000; op2 = 16'h0000; cond = 3'b000; signed_mode = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_idle", {30'b0, in_ready, out_valid}, 32'h2);
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) lat++;
            step();
        end
        check("flush_no_valid", lat, 32'd0);
        check("flush_cnt", {24'b0, taken_cnt}, 32'd6);

        // Flush beats out_ready in DONE: no transfer counted.
        issue(16'h0000, 16'h0000, 3'b110, 1'b0, lat);
        check("flush_done_latency", lat, 32'd4);
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; out_ready = 1'b0;
        check("flush_done_idle", {30'b0, in_ready, out_valid}, 32'h2);
        check("flush_done_cnt", {24'b0, taken_cnt}, 32'd6);

        // Reset while in DONE.
        issue(16'h5000, 16'h4000, 3'b100, 1'b0, lat);
        check("rst_done_latency", lat, 32'd1);
        rst_n = 1'b0; out_ready = 1'b1;
        step();
        rst_n = 1'b1; out_ready = 1'b0;
        check("rst_done_idle", {30'b0, in_ready, out_valid}, 32'h2);
        check("rst_done_cnt", {24'b0, taken_cnt}, 32'd0);
        check("rst_done_result", {29'b0, result, taken}, 32'd0);

        // Saturation: 255 ALWAYS transfers, then one more.
        for (int i = 0; i < 255; i++) begin
            issue(16'h1000, 16'h0000, 3'b110, 1'b0, lat);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        check("sat_255", {24'b0, taken_cnt}, 32'd255);
        txn("sat_hold",   16'h1000, 16'h0000, 3'b110, 0,   1, 2'b01, 1, 8'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/st2_branch_resolver.md
ST2_BRANCH_RESOLVER -- requirements
Module: st2_branch_resolver

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of CHUNK, >= CHUNK.
REQ-002 Parameter CHUNK, default 4, bits compared per clock cycle; NCHUNK = WIDTH/CHUNK.
REQ-003 Parameter CNT_W, default 8, width of the taken-branch statistics counter.
REQ-004 Port clk  input  1  rising-edge clock; the one clock.
REQ-005 Port rst_n  input  1  reset; synchronous, active-low.
REQ-006 Port in_valid  input  1  request valid.
REQ-007 Port in_ready  output  1  block can accept a request.
REQ-008 Port op1  input  WIDTH  first operand.
REQ-009 Port op2  input  WIDTH  second operand (the register the branch tests against).
REQ-010 Port cond  input  3  branch condition: 000 BEQ, 001 BNE, 010 BLT, 011 BGE, 100 BGT, 101 BLE, 110 ALWAYS, 111 NEVER.
REQ-011 Port signed_mode  input  1  1 = two's-complement compare, 0 = unsigned.
REQ-012 Port flush  input  1  abort current request (pipeline squash).
REQ-013 Port out_valid  output  1  result valid.
REQ-014 Port out_ready  input  1  consumer accepts result.
REQ-015 Port result  output  2  relation of op1 to op2: 00 equal, 01 greater, 10 less; 11 never driven.
REQ-016 Port taken  output  1  branch decision for latched cond.
REQ-017 Port taken_cnt  output  CNT_W  saturating count of delivered taken results.

Function
REQ-018 FSM states IDLE, CMP, DONE; in_ready SHALL be 1 only in IDLE.
REQ-019 Accept = in_valid & in_ready & !flush; on accept, op1, op2, cond, signed_mode latched, chunk index = NCHUNK-1, state -> CMP.
REQ-020 In CMP, one CHUNK-bit slice per cycle, MSB slice first; index decrements each cycle.
REQ-021 For the MSB slice with latched signed_mode=1, slice MSBs SHALL be inverted before compare.
REQ-022 First unequal slice SHALL end compare: result = 01/10 per that slice, state -> DONE (early exit).
REQ-023 All slices equal (index 0 reached equal) -> result 00, state -> DONE.
REQ-024 Latency: out_valid SHALL rise k cycles after accept edge, k = slices examined (1..NCHUNK); result, taken registered together with out_valid.
REQ-025 taken SHALL be decoded from result and latched cond; ALWAYS=1, NEVER=0 regardless of result (compare still runs).
REQ-026 In DONE, out_valid=1; result and taken SHALL hold stable until out_ready=1; transfer -> IDLE next cycle.
REQ-027 taken_cnt SHALL increment on each transfer with taken=1, saturating at all-ones (no wrap).
REQ-028 flush SHALL, from any state, force IDLE next cycle, out_valid=0, no transfer and no counter increment; flush beats in_valid and out_ready in the same cycle.
REQ-029 No new request accepted in the cycle a DONE transfer occurs (one request in flight).

Reset
REQ-030 rst_n low at a rising clk SHALL set state IDLE, out_valid 0, result 00, taken 0, taken_cnt 0, latched operands 0; in_ready 1 after that edge.
REQ-031 Reset mid-CMP or mid-DONE SHALL discard the request without producing out_valid.

Structure
REQ-032 Shared package holds cond encodings, result encodings (EQ/GT/LT) and FSM state typedef.
REQ-033 One sub-module natural: st2_chunk_cmp (combinational CHUNK-bit slice compare with invert-MSB input, outputs eq/gt).

Verification (WIDTH=16, CHUNK=4)
REQ-034 op1=0000, op2=0000, BEQ, unsigned -> out_valid 4 cycles after accept, result=00, taken=1, taken_cnt=1 after transfer.
REQ-035 op1=0001, op2=0000, BGT -> 4 cycles, result=01, taken=1; same with BLE -> taken=0, counter unchanged.
REQ-036 op1=8000, op2=0001, BLT: signed -> 1 cycle, result=10, taken=1; unsigned -> 1 cycle, result=01, taken=0.
REQ-037 op1=FFFA, op2=FFFF signed, BLT, out_ready held 0 for 5 cycles -> result=10, taken=1 stable, in_ready=0 throughout, single transfer.
REQ-038 flush in 2nd CMP cycle, and separately rst_n low in DONE -> IDLE next cycle, no out_valid, taken_cnt unchanged (reset: 0).
REQ-039 taken_cnt preloaded to 255 via 255 ALWAYS requests (CNT_W=8), one more ALWAYS -> stays 255.
